// File: rtl/spsa_cost_unit_if.sv
// spsa_cost_unit_if: perceptron/network handshake inputs and cost/error outputs of the cost unit
interface spsa_cost_unit_if #(
    parameter int BITWIDTH = 18,
    parameter int CNT_W    = 16
);
    logic [BITWIDTH-1:0] netOut;
    logic                netOutReady;
    logic                label;
    logic                trainingReady;
    logic [BITWIDTH-1:0] costFunc;
    logic                newCostFunc;
    logic                roundOut;
    logic [CNT_W-1:0]    errCount;
    logic                errValid;
    logic                busy;

    modport master (
        output netOut, netOutReady, label, trainingReady,
        input  costFunc, newCostFunc, roundOut, errCount, errValid, busy
    );

    modport slave (
        input  netOut, netOutReady, label, trainingReady,
        output costFunc, newCostFunc, roundOut, errCount, errValid, busy
    );
endinterface

// File: rtl/spsa_cost_unit.sv
// spsa_cost_unit: sigmoid + squared-error cost difference for SPSA training, with windowed misclassification count
module spsa_cost_unit #(
    parameter int QN       = 6,
    parameter int QM       = 11,
    parameter int BITWIDTH = QN + QM + 1,
    parameter int SCALE_SH = 5,
    parameter int WINDOW   = 1000,
    parameter int CNT_W    = 16
) (
    input logic clock_i,
    input logic reset_ni,
    spsa_cost_unit_if.slave bus
);
    localparam int SW = QM + 1;
    localparam int DW = QM + 2 + SCALE_SH;
    localparam int WW = (DW > BITWIDTH ? DW : BITWIDTH) + 1;
    localparam logic [SW-1:0] ONE = SW'(1) << QM;
    localparam logic [SW-1:0] HALF = SW'(1) << (QM - 1);
    localparam logic [SW-1:0] C_HI = SW'(27) << (QM - 5);
    localparam logic [SW-1:0] C_MID = SW'(5) << (QM - 3);
    localparam logic [BITWIDTH-1:0] XMIN = BITWIDTH'(1) << (BITWIDTH - 1);
    localparam logic [BITWIDTH-1:0] T_HI = BITWIDTH'(5) << QM;
    localparam logic [BITWIDTH-1:0] T_MID = BITWIDTH'(19) << (QM - 3);
    localparam logic [BITWIDTH-1:0] T_LO = BITWIDTH'(1) << QM;
    localparam logic signed [WW-1:0] DMAX = WW'((64'sd1 <<< (BITWIDTH - 1)) - 64'sd1);
    localparam logic signed [WW-1:0] DMIN = ~DMAX;

    typedef enum logic [2:0] {IDLE, SIG_N, SQ_N, WAIT_P, SIG_P, SQ_P, EMIT, WAIT_T} state_t;

    state_t state_q, state_d;
    logic nrdy_q, trdy_q, label_q, new_q, round_q, errv_q;
    logic [BITWIDTH-1:0] x_q, cost_q, a, cost_d;
    logic [SW-1:0] s_q, j_q, jp_q, s_abs, s_d, e_abs, j_d;
    logic [2*SW-1:0] e_sq;
    logic signed [WW-1:0] d_full;
    logic [CNT_W-1:0] acc_q, win_q, err_q, win_n, acc_n;
    logic n_rise, t_rise, miss;

    // Rise detection, piecewise-linear sigmoid, squared error and saturated scaled cost difference
    always_comb begin
        n_rise = bus.netOutReady & ~nrdy_q;
        t_rise = bus.trainingReady & ~trdy_q;
        a = x_q[BITWIDTH-1] ? (x_q == XMIN ? ~XMIN : -x_q) : x_q;
        s_abs = a >= T_HI ? ONE : a >= T_MID ? SW'(a >> 5) + C_HI : a >= T_LO ? SW'(a >> 3) + C_MID : SW'(a >> 2) + HALF;
        s_d = x_q[BITWIDTH-1] ? ONE - s_abs : s_abs;
        e_abs = label_q ? ONE - s_q : s_q;
        e_sq = e_abs * e_abs;
        j_d = SW'(e_sq >> QM);
        d_full = (WW'(jp_q) - WW'(j_q)) <<< SCALE_SH;
        cost_d = d_full > DMAX ? DMAX[BITWIDTH-1:0] : d_full < DMIN ? DMIN[BITWIDTH-1:0] : d_full[BITWIDTH-1:0];
        miss = (s_q >= HALF) != label_q;
        win_n = win_q + CNT_W'(1);
        acc_n = acc_q + CNT_W'(miss);
    end

    // Sequencing: nominal pass, perturbed pass, emit, then wait for the network
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = n_rise ? SIG_N : IDLE;
            SIG_N:   state_d = SQ_N;
            SQ_N:    state_d = WAIT_P;
            WAIT_P:  state_d = n_rise ? SIG_P : WAIT_P;
            SIG_P:   state_d = SQ_P;
            SQ_P:    state_d = EMIT;
            EMIT:    state_d = WAIT_T;
            WAIT_T:  state_d = t_rise ? IDLE : WAIT_T;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Datapath: captures, pipeline registers, strobes and the error window
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            nrdy_q  <= 1'b0;
            trdy_q  <= 1'b0;
            label_q <= 1'b0;
            new_q   <= 1'b0;
            round_q <= 1'b0;
            errv_q  <= 1'b0;
            x_q     <= '0;
            cost_q  <= '0;
            s_q     <= '0;
            j_q     <= '0;
            jp_q    <= '0;
            acc_q   <= '0;
            win_q   <= '0;
            err_q   <= '0;
        end else begin
            nrdy_q <= bus.netOutReady;
            trdy_q <= bus.trainingReady;
            new_q  <= 1'b0;
            errv_q <= 1'b0;
            if ((state_q == IDLE || state_q == WAIT_P) && n_rise) x_q <= bus.netOut;
            if (state_q == IDLE && n_rise) label_q <= bus.label;
            if (state_q == SIG_N || state_q == SIG_P) s_q <= s_d;
            if (state_q == SQ_N) begin
                j_q     <= j_d;
                round_q <= s_q >= HALF;
                if (win_n == CNT_W'(WINDOW)) begin
                    err_q  <= acc_n;
                    errv_q <= 1'b1;
                    acc_q  <= '0;
                    win_q  <= '0;
                end else begin
                    acc_q <= acc_n;
                    win_q <= win_n;
                end
            end
            if (state_q == SQ_P) jp_q <= j_d;
            if (state_q == EMIT) begin
                cost_q <= cost_d;
                new_q  <= 1'b1;
            end
        end
    end

    assign bus.costFunc    = cost_q;
    assign bus.newCostFunc = new_q;
    assign bus.roundOut    = round_q;
    assign bus.errCount    = err_q;
    assign bus.errValid    = errv_q;
    assign bus.busy        = state_q != IDLE;
endmodule
